imem_port_arbiter: RTL
======================

// Module: imem_port_arbiter
// PURPOSE
//  Sequences and shares the single byte-wide instruction-memory port between two requesters.
//  Fetch requester: 32-bit big-endian word reads, assembled from 4 byte beats.
//  Loader requester: single-byte program writes (preload/debug).
//  Sits between the fetch stage / program loader and the 512 x 8 instruction memory array.
// PARAMETERS
//  ADDR_W     9    byte-address width; memory depth = 2**ADDR_W bytes
//  FETCH_FIRST 1   priority on the very first contention after reset (1 = fetch, 0 = loader)
// PORTS
//  clk         in   1       system clock, rising edge
//  reset       in   1       asynchronous, active-high
//  fetch_req   in   1       fetch request; held high until fetch_valid
//  fetch_addr  in   ADDR_W  fetch byte address; sampled at grant
//  fetch_valid out  1       one-cycle pulse: fetch_data/fetch_err valid
//  fetch_data  out  32      {M[a],M[a+1],M[a+2],M[a+3]}
//  fetch_err   out  1       misaligned fetch (see CONFIGURATION); qualified by fetch_valid
//  ld_req      in   1       loader write request; held high until ld_ack
//  ld_addr     in   ADDR_W  write byte address
//  ld_data     in   8       write byte
//  ld_ack      out  1       one-cycle pulse: byte written this cycle
//  mem_addr    out  ADDR_W  memory byte address
//  mem_we      out  1       memory write enable
//  mem_wdata   out  8       memory write data
//  mem_rdata   in   8       memory read data, combinational from mem_addr (same cycle)
// BEHAVIOUR
//  Reset: state=IDLE, beat=0, all outputs 0, word buffer 0, last_grant = fetch if FETCH_FIRST=1, else loader.
//  States: IDLE -> FETCH (beats 0..3) -> FDONE -> IDLE;  IDLE -> WRITE -> IDLE;  IDLE -> FERR -> IDLE.
//  IDLE: only fetch_req -> grant fetch; only ld_req -> grant loader.
//    Both requests: round-robin; grant the requester not in last_grant. last_grant updates on every grant.
//  Fetch grant at edge T: latch base = fetch_addr. FETCH occupies cycles T+1..T+4.
//    Each cycle: mem_addr = base+beat (mod 2**ADDR_W), mem_we=0; rdata captured into byte lane 3-beat at edge.
//    FDONE (T+5): fetch_valid=1, fetch_data=assembled word, fetch_err=0. Total latency 5 cycles from grant.
//  Loader grant at edge T: WRITE at T+1: mem_addr=ld_addr, mem_wdata=ld_data, mem_we=1, ld_ack=1.
//    ld_addr/ld_data must be held through T+1.
//  Wrap-around: base 0x1FE reads bytes 0x1FE, 0x1FF, 0x000, 0x001 (only reachable with ALIGN_CHECK off).
//  mem_we is high only in WRITE; in IDLE/FDONE/FERR, mem_addr=0 and mem_wdata=0.
//  Arbiter returns to IDLE after each transaction; a new grant is possible on the following edge.
//    Back-to-back same-requester streams therefore alternate when both are requesting.
//  fetch_data holds its last value until the next FDONE. fetch_valid and ld_ack are single-cycle pulses.
//  Requests dropped mid-transaction are ignored; the transaction completes (FETCH) or has already committed (WRITE).
//  Reset mid-FETCH: partial word discarded, no fetch_valid, IDLE on release.
//  Reset mid-WRITE: write aborted; mem_we falls asynchronously.
// CONFIGURATION
//  `IMEM_ARB_ALIGN_CHECK_EN defined:
//    A fetch grant with fetch_addr[1:0] != 0 goes to FERR, with no memory beats.
//    FERR (T+1): fetch_valid=1, fetch_err=1, fetch_data=32'h0.
//  Not defined: no check; misaligned fetches run the normal 4 beats with wrap. fetch_err is tied to 0.
// TESTING
//  1 Preload M[0x10..0x13] = 8C,22,00,04 via the loader; fetch_req at addr 0x010.
//    -> fetch_valid 5 cycles after grant; fetch_data = 32'h8C220004; fetch_err = 0.
//  2 ld_req addr 0x1FF data 0xA5 -> ld_ack 1 cycle after grant; mem_we=1 for exactly 1 cycle.
//    Subsequent fetch at 0x1FC returns low byte A5.
//  3 fetch_req and ld_req held together from reset, FETCH_FIRST=1.
//    -> grants alternate F, L, F, L; no requester starves; 4 completions within 14 cycles.
//  4 With IMEM_ARB_ALIGN_CHECK_EN, fetch 0x011 -> fetch_valid 1 cycle after grant, fetch_err=1, data 0, mem_addr idle.
//    Without the macro, fetch 0x1FE -> bytes {M[1FE],M[1FF],M[000],M[001]}.
//  5 Assert reset during FETCH beat 2 -> no fetch_valid; all outputs 0 asynchronously.
//    After release, refetching the same address returns the correct full word.
//  6 Drop fetch_req during beat 1 -> fetch still completes with fetch_valid pulse; next IDLE has no spurious grant.

Source files
------------

// File: rtl/imem_port_arbiter.sv
// Shares the byte-wide instruction-memory port between the fetch stage (4-beat big-endian
// word reads) and the program loader (single-byte writes). Round-robin on contention.
// Optional feature: define IMEM_ARB_ALIGN_CHECK_EN to reject fetches whose address is not
// word aligned (fetch_err); otherwise misaligned fetches read 4 bytes with address wrap.
module imem_port_arbiter #(
  parameter int unsigned ADDR_W      = 9,
  parameter bit          FETCH_FIRST = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic              fetch_valid,
  output logic [31:0]       fetch_data,
  output logic              fetch_err,
  input  logic              ld_req,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [7:0]        ld_data,
  output logic              ld_ack,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata
);

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StFetch = 3'd1,
    StFdone = 3'd2,
    StWrite = 3'd3,
    StFerr  = 3'd4
  } state_e;

  state_e              state_q, state_d;
  logic [1:0]          beat_q, beat_d;
  logic [ADDR_W-1:0]   base_q, base_d;
  logic [31:0]         word_q, word_d;
  logic [31:0]         data_q, data_d;
  // 1 = the most recent grant went to fetch; contention favours the other requester.
  logic                last_fetch_q, last_fetch_d;

  logic                fetch_misaligned;

`ifdef IMEM_ARB_ALIGN_CHECK_EN
  assign fetch_misaligned = (fetch_addr[1:0] != 2'b00);
`else
  assign fetch_misaligned = 1'b0;
`endif

  // State register; outputs decode from state_q so reset clears them asynchronously.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= StIdle;
      beat_q       <= 2'd0;
      base_q       <= '0;
      word_q       <= '0;
      data_q       <= '0;
      // Pretend the loader was granted last so FETCH_FIRST=1 gives fetch the first contention.
      last_fetch_q <= ~FETCH_FIRST;
    end else begin
      state_q      <= state_d;
      beat_q       <= beat_d;
      base_q       <= base_d;
      word_q       <= word_d;
      data_q       <= data_d;
      last_fetch_q <= last_fetch_d;
    end
  end

  // Arbitration, beat sequencing and word assembly.
  always_comb begin
    state_d      = state_q;
    beat_d       = beat_q;
    base_d       = base_q;
    word_d       = word_q;
    data_d       = data_q;
    last_fetch_d = last_fetch_q;
    unique case (state_q)
      StIdle: begin
        if (fetch_req && (!ld_req || !last_fetch_q)) begin
          last_fetch_d = 1'b1;
          base_d       = fetch_addr;
          beat_d       = 2'd0;
          if (fetch_misaligned) begin
            state_d = StFerr;
            data_d  = 32'h0;
          end else begin
            state_d = StFetch;
          end
        end else if (ld_req) begin
          last_fetch_d = 1'b0;
          state_d      = StWrite;
        end
      end
      StFetch: begin
        // Beat n lands in byte lane 3-n: first byte read is the most significant.
        unique case (beat_q)
          2'd0: word_d[31:24] = mem_rdata;
          2'd1: word_d[23:16] = mem_rdata;
          2'd2: word_d[15:8]  = mem_rdata;
          2'd3: word_d[7:0]   = mem_rdata;
          default: ;
        endcase
        beat_d = beat_q + 2'd1;
        if (beat_q == 2'd3) begin
          state_d = StFdone;
          data_d  = {word_q[31:8], mem_rdata};
        end
      end
      StFdone, StWrite, StFerr: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Memory port and handshake outputs; idle states drive zeros.
  always_comb begin
    mem_addr    = '0;
    mem_we      = 1'b0;
    mem_wdata   = 8'h00;
    ld_ack      = 1'b0;
    fetch_valid = 1'b0;
    unique case (state_q)
      StFetch: mem_addr = base_q + ADDR_W'(beat_q);
      StWrite: begin
        mem_addr  = ld_addr;
        mem_wdata = ld_data;
        mem_we    = 1'b1;
        ld_ack    = 1'b1;
      end
      StFdone: fetch_valid = 1'b1;
      StFerr:  fetch_valid = 1'b1;
      default: ;
    endcase
  end

  assign fetch_data = data_q;

`ifdef IMEM_ARB_ALIGN_CHECK_EN
  assign fetch_err = (state_q == StFerr);
`else
  assign fetch_err = 1'b0;
`endif

endmodule
